chi_request_node: RTL and testbench
===================================

CHI_REQUEST_NODE -- requirements
Module: chi_request_node

Interface
REQ-001 The block SHALL provide parameter DEPTH, default 4, as the request FIFO depth in entries, which SHALL be a power of two and at least 2.
REQ-002 The block SHALL provide parameter TIMEOUT_CYCLES, default 16, as the number of WAIT cycles before a timeout completion.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  client request present.
REQ-006 req_ready  output  1  FIFO can accept a request.
REQ-007 req_addr  input  32  client byte address.
REQ-008 req_cmd  input  4  client command: 4'b0001 is read, 4'b0010 is write.
REQ-009 req_wdata  input  32  client write data.
REQ-010 cpl_valid  output  1  completion present.
REQ-011 cpl_ready  input  1  client accepts the completion.
REQ-012 cpl_rdata  output  32  read data, or 0 for writes and errors.
REQ-013 cpl_err  output  1  flags an unsupported command or a timeout.
REQ-014 addr  output  32  address to the slave node.
REQ-015 command  output  4  command to the slave node.
REQ-016 write_data  output  32  write data to the slave node.
REQ-017 request_valid  output  1  request strobe to the slave node.
REQ-018 read_data  input  32  read data from the slave node.
REQ-019 response_valid  input  1  response strobe from the slave node.

Function
REQ-020 req_ready SHALL equal NOT full, and a request SHALL be pushed on every cycle where req_valid and req_ready are both high.
REQ-021 A push and a pop in the same cycle SHALL leave the occupancy unchanged, and the FIFO pointers SHALL wrap modulo DEPTH.
REQ-022 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT and CPL.
REQ-023 In IDLE with the FIFO non-empty, the FSM SHALL pop the head entry: on read or write it SHALL go to ISSUE; on any other command it SHALL go to CPL with cpl_err=1 and cpl_rdata=0, and SHALL NOT issue the request.
REQ-024 In ISSUE, request_valid SHALL be 1 for exactly one cycle, with addr, command and write_data driven from the popped entry; the FSM SHALL then go to WAIT.
REQ-025 addr, command and write_data SHALL be registered and SHALL hold their last values outside ISSUE.
REQ-026 In WAIT, response_valid=1 SHALL move the FSM to CPL with cpl_err=0; cpl_rdata SHALL be read_data for a read and 0 for a write.
REQ-027 response_valid outside WAIT SHALL be ignored.
REQ-028 There SHALL be at most one outstanding slave transaction.
REQ-029 In CPL, cpl_valid SHALL be 1, with cpl_rdata and cpl_err held stable, until the cycle where cpl_ready is high; the FSM SHALL then go to IDLE.
REQ-030 Latency: request_valid SHALL assert in the second cycle after a push into an empty FIFO while the FSM is in IDLE.
REQ-031 Latency: cpl_valid SHALL assert one cycle after response_valid is seen in WAIT.

Reset
REQ-032 While reset is high at a clock edge, the FSM SHALL enter IDLE and the FIFO SHALL be emptied.
REQ-033 During reset, req_ready, cpl_valid, cpl_err, request_valid, cpl_rdata, addr, command and write_data SHALL all be 0.
REQ-034 Reset mid-transaction SHALL discard both the in-flight transaction and any queued entries.
REQ-035 A response_valid arriving after reset SHALL be ignored, because the FSM is in IDLE.
REQ-036 req_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-037 With macro CHI_RN_TIMEOUT_EN defined, a counter SHALL clear on entry to WAIT and count WAIT cycles; on reaching TIMEOUT_CYCLES without a response, the FSM SHALL go to CPL with cpl_err=1 and cpl_rdata=0.
REQ-038 With CHI_RN_TIMEOUT_EN defined, a response_valid arriving in the same cycle as the limit SHALL take priority over the timeout.
REQ-039 Without CHI_RN_TIMEOUT_EN, WAIT SHALL persist until response_valid is seen, and no counter logic SHALL exist.

Verification
REQ-040 Write addr=0x10, data=0xDEADBEEF, then read addr=0x10 against the slave model -> request_valid pulses once per request; completions are (rdata=0, err=0) then (rdata=0xDEADBEEF, err=0).
REQ-041 Push 5 requests back-to-back with DEPTH=4 and the slave stalled -> req_ready=0 after 4 accepts; the 5th is accepted after the first pop; completions arrive in order.
REQ-042 Push req_cmd=4'b0111 -> request_valid stays 0; one completion with err=1 and rdata=0.
REQ-043 With CHI_RN_TIMEOUT_EN, read with response_valid held 0 -> completion err=1 exactly 16 WAIT cycles after ISSUE; with the macro undefined -> no completion after 100 cycles.
REQ-044 Hold cpl_ready=0 for 3 cycles -> cpl_valid and cpl_rdata are stable; a subsequent FIFO entry is not issued until the handshake.
REQ-045 Assert reset while in WAIT with 2 entries queued -> all outputs are 0 and req_ready=1 afterwards; a late response_valid produces no completion.

Source files
------------

// File: rtl/chi_request_node_if.sv
// rtl/chi_request_node_if.sv - client request/completion and slave-node bus bundle for chi_request_node
interface chi_request_node_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [3:0]  req_cmd;
    logic [31:0] req_wdata;
    logic        cpl_valid;
    logic        cpl_ready;
    logic [31:0] cpl_rdata;
    logic        cpl_err;
    logic [31:0] addr;
    logic [3:0]  command;
    logic [31:0] write_data;
    logic        request_valid;
    logic [31:0] read_data;
    logic        response_valid;

    modport master (
        input  req_valid, req_addr, req_cmd, req_wdata, cpl_ready, read_data, response_valid,
        output req_ready, cpl_valid, cpl_rdata, cpl_err, addr, command, write_data, request_valid
    );

    modport slave (
        output req_valid, req_addr, req_cmd, req_wdata, cpl_ready, read_data, response_valid,
        input  req_ready, cpl_valid, cpl_rdata, cpl_err, addr, command, write_data, request_valid
    );
endinterface

// File: rtl/chi_request_node.sv
// rtl/chi_request_node.sv - request node: request FIFO, single-outstanding issue FSM, completion return
// Optional WAIT timeout enabled by defining CHI_RN_TIMEOUT_EN.
module chi_request_node #(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset,
    chi_request_node_if.master bus
);
    localparam int              AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CW        = AW + 1;
    localparam logic [AW-1:0]   PTR_ONE   = AW'(1);
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]   CNT_FULL  = CW'(DEPTH);
    localparam logic [3:0]      CMD_READ  = 4'b0001;
    localparam logic [3:0]      CMD_WRITE = 4'b0010;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_CPL   = 2'd3;

    logic [31:0]   r_fifo_addr  [DEPTH];
    logic [3:0]    r_fifo_cmd   [DEPTH];
    logic [31:0]   r_fifo_wdata [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [1:0]    r_state;
    logic [31:0]   r_addr;
    logic [3:0]    r_cmd;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    logic          r_err;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_head_ok;
    logic w_timeout;

    assign w_full    = (r_count == CNT_FULL);
    assign w_empty   = (r_count == '0);
    assign w_push    = bus.req_valid && !w_full && !reset;
    assign w_pop     = (r_state == S_IDLE) && !w_empty;
    assign w_head_ok = (r_fifo_cmd[r_rd_ptr] == CMD_READ) || (r_fifo_cmd[r_rd_ptr] == CMD_WRITE);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr]  <= bus.req_addr;
            r_fifo_cmd[r_wr_ptr]   <= bus.req_cmd;
            r_fifo_wdata[r_wr_ptr] <= bus.req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef CHI_RN_TIMEOUT_EN
    localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] r_tmo_cnt;

    // Held at zero outside WAIT, so every WAIT entry starts a fresh count.
    always_ff @(posedge clk) begin
        if (reset || r_state != S_WAIT) r_tmo_cnt <= '0;
        else                            r_tmo_cnt <= r_tmo_cnt + TW'(1);
    end
    assign w_timeout = (r_state == S_WAIT) && (r_tmo_cnt == TMO_LAST);
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
    assign w_timeout    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_cmd   <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_pop) begin
                    if (w_head_ok) begin
                        r_addr  <= r_fifo_addr[r_rd_ptr];
                        r_cmd   <= r_fifo_cmd[r_rd_ptr];
                        r_wdata <= r_fifo_wdata[r_rd_ptr];
                        r_state <= S_ISSUE;
                    end else begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                        r_state <= S_CPL;
                    end
                end
                S_ISSUE: r_state <= S_WAIT;
                // A response in the limit cycle wins over the timeout.
                S_WAIT: if (bus.response_valid) begin
                    r_rdata <= (r_cmd == CMD_READ) ? bus.read_data : 32'h0;
                    r_err   <= 1'b0;
                    r_state <= S_CPL;
                end else if (w_timeout) begin
                    r_rdata <= '0;
                    r_err   <= 1'b1;
                    r_state <= S_CPL;
                end
                S_CPL: if (bus.cpl_ready) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready     = !w_full && !reset;
    assign bus.request_valid = (r_state == S_ISSUE) && !reset;
    assign bus.cpl_valid     = (r_state == S_CPL) && !reset;
    assign bus.cpl_rdata     = reset ? 32'h0 : r_rdata;
    assign bus.cpl_err       = r_err && !reset;
    assign bus.addr          = reset ? 32'h0 : r_addr;
    assign bus.command       = reset ? 4'h0 : r_cmd;
    assign bus.write_data    = reset ? 32'h0 : r_wdata;
endmodule

// File: tb/tb_chi_request_node.sv
// tb/tb_chi_request_node.sv - scoreboard bench for chi_request_node with a stallable slave-node model
module tb_chi_request_node;
    localparam logic [3:0] RD = 4'b0001;
    localparam logic [3:0] WR = 4'b0010;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    chi_request_node_if bus();

    chi_request_node #(.DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_cpl = 0;
    int req_pulses = 0;
    int req_cyc = 0;
    int resp_cyc = 0;
    int cpl_rise_cyc = 0;
    int push_cyc = 0;
    logic slv_stall = 1'b0;
    logic slv_pending = 1'b0;
    logic cpl_prev = 1'b0;
    logic [31:0] slv_rdata = 32'h0;
    logic [31:0] slv_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    logic [32:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=0x%08h exp=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_req_ready"},     32'(bus.req_ready),     32'd0);
        check_eq({tag, "_cpl_valid"},     32'(bus.cpl_valid),     32'd0);
        check_eq({tag, "_cpl_err"},       32'(bus.cpl_err),       32'd0);
        check_eq({tag, "_request_valid"}, 32'(bus.request_valid), 32'd0);
        check_eq({tag, "_cpl_rdata"},     bus.cpl_rdata,          32'd0);
        check_eq({tag, "_addr"},          bus.addr,               32'd0);
        check_eq({tag, "_command"},       32'(bus.command),       32'd0);
        check_eq({tag, "_write_data"},    bus.write_data,         32'd0);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push_req(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_cmd   = cmd;
        bus.req_addr  = a;
        bus.req_wdata = d;
        @(negedge clk);
        while (!bus.req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_eq("push_accept", 32'(bus.req_ready), 32'd1);
        push_cyc = cyc;
        if (cmd == RD) begin
            exp_q.push_back({1'b0, ref_mem.exists(a) ? ref_mem[a] : 32'h0});
        end else if (cmd == WR) begin
            ref_mem[a] = d;
            exp_q.push_back(33'h0);
        end else begin
            exp_q.push_back({1'b1, 32'h0});
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_cpl(input int target, input string tag);
        int n = 0;
        while (n_cpl < target && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(n_cpl), 32'(target));
        @(posedge clk);
        #1;
    endtask

    // Slave node: answers each request one cycle after it is seen unless stalled.
    initial begin
        bus.response_valid = 1'b0;
        bus.read_data      = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            bus.response_valid = 1'b0;
            bus.read_data      = 32'h5A5A_0000;
            if (slv_pending && !slv_stall) begin
                bus.response_valid = 1'b1;
                bus.read_data      = slv_rdata;
                slv_pending        = 1'b0;
                resp_cyc           = cyc;
            end
            if (bus.request_valid) begin
                req_pulses++;
                req_cyc = cyc;
                if (bus.command == WR) begin
                    slv_mem[bus.addr] = bus.write_data;
                    slv_rdata = 32'hA5A5_A5A5;
                end else begin
                    slv_rdata = slv_mem.exists(bus.addr) ? slv_mem[bus.addr] : 32'h0;
                end
                slv_pending = 1'b1;
            end
        end
    end

    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (bus.cpl_valid && !cpl_prev) cpl_rise_cyc = cyc;
            cpl_prev = bus.cpl_valid;
            if (bus.cpl_valid && bus.cpl_ready) begin
                n_cpl++;
                check_eq("cpl_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_eq("cpl_rdata", bus.cpl_rdata, e[31:0]);
                    check_eq("cpl_err", 32'(bus.cpl_err), 32'(e[32]));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int c0;
        int pc;
        int n;
        bus.req_valid = 1'b0;
        bus.req_addr  = 32'h0;
        bus.req_cmd   = 4'h0;
        bus.req_wdata = 32'h0;
        bus.cpl_ready = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("rst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("rdy_after_rst", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;

        // Write then read back through the slave model
        p0 = req_pulses;
        push_req(WR, 32'h10, 32'hDEAD_BEEF);
        pc = push_cyc;
        wait_cpl(1, "cpl_cnt_wr");
        check_eq("issue_latency", 32'(req_cyc - pc), 32'd2);
        check_eq("cpl_latency", 32'(cpl_rise_cyc - resp_cyc), 32'd1);
        check_eq("last_addr", bus.addr, 32'h10);
        push_req(RD, 32'h10, 32'h0);
        wait_cpl(2, "cpl_cnt_rd");
        check_eq("pulses_wr_rd", 32'(req_pulses - p0), 32'd2);

        // Fill the FIFO behind a stalled transaction
        slv_stall = 1'b1;
        push_req(RD, 32'h10, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        push_req(WR, 32'h20, 32'h1111);
        push_req(RD, 32'h20, 32'h0);
        push_req(WR, 32'h24, 32'h2222);
        push_req(RD, 32'h24, 32'h0);
        @(negedge clk);
        check_eq("full_rdy", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1;
        slv_stall = 1'b0;
        push_req(WR, 32'h28, 32'h3333);
        wait_cpl(8, "cpl_cnt_order");

        // Unsupported command
        p0 = req_pulses;
        push_req(4'b0111, 32'h40, 32'h5);
        wait_cpl(9, "cpl_cnt_bad");
        check_eq("bad_no_issue", 32'(req_pulses - p0), 32'd0);

        // Slave never answers
        slv_stall = 1'b1;
        push_req(RD, 32'h20, 32'h0);
`ifdef CHI_RN_TIMEOUT_EN
        exp_q[exp_q.size() - 1] = {1'b1, 32'h0};
        wait_cpl(10, "cpl_cnt_tmo");
        check_eq("tmo_latency", 32'(cpl_rise_cyc - req_cyc), 32'd17);
        slv_pending = 1'b0;
        slv_stall   = 1'b0;
`else
        repeat (100) @(posedge clk);
        #1;
        check_eq("no_cpl_100", 32'(n_cpl), 32'd9);
        slv_stall = 1'b0;
        wait_cpl(10, "cpl_cnt_late_rsp");
`endif

        // Completion back-pressure
        bus.cpl_ready = 1'b0;
        p0 = req_pulses;
        push_req(RD, 32'h24, 32'h0);
        push_req(WR, 32'h2C, 32'h4444);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.cpl_valid && n < 50);
        for (int i = 0; i < 3; i++) begin
            check_eq("hold_valid", 32'(bus.cpl_valid), 32'd1);
            check_eq("hold_rdata", bus.cpl_rdata, 32'h2222);
            check_eq("hold_no_issue", 32'(req_pulses - p0), 32'd1);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.cpl_ready = 1'b1;
        wait_cpl(12, "cpl_cnt_bp");

        // Reset while in WAIT with two entries queued
        slv_stall = 1'b1;
        p0 = req_pulses;
        c0 = n_cpl;
        push_req(RD, 32'h10, 32'h0);
        push_req(RD, 32'h20, 32'h0);
        push_req(RD, 32'h24, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("wait_one_issued", 32'(req_pulses - p0), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_zero("rst_mid");
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_eq("rdy_after_rst2", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        slv_stall = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check_eq("no_cpl_after_rst", 32'(n_cpl), 32'(c0));
        check_eq("no_issue_after_rst", 32'(req_pulses - p0), 32'd1);
        check_eq("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
